// File: rtl/mem_bank_pkg.sv
`default_nettype none
// mem_bank_pkg -- shared types and helpers for the mem_bank_p memory.
// Rev 1.0
package mem_bank_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int DW_DEFAULT = 16;
    localparam int NLANES     = DW_DEFAULT / 8;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DW    = 128;
    localparam int MAX_LANES = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0]    old_word,
        input logic [MAX_DW-1:0]    new_word,
        input logic [MAX_LANES-1:0] strb
    );
        logic [MAX_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bank_p_rd_pipe.sv
`default_nettype none
// mem_rd_pipe -- STAGES-deep shift of {valid, err, data}; data only advances with valid.
// Rev 1.0
module mem_rd_pipe #(
    parameter int DW     = 16,
    parameter int STAGES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_err,
    output logic [DW-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};
            assign out_valid      = in_valid;
            assign out_err        = in_err;
            assign out_data       = in_data;
        end else begin : g_shift
            logic [STAGES-1:0] valid_q;
            logic [STAGES-1:0] err_q;
            logic [DW-1:0]     data_q [STAGES];

            // Data moves only alongside a valid so the last response stays visible.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                    err_q   <= '0;
                    for (int i = 0; i < STAGES; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q[0] <= in_valid;
                    err_q[0]   <= in_err;
                    if (in_valid) begin
                        data_q[0] <= in_data;
                    end
                    for (int i = 1; i < STAGES; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        err_q[i]   <= err_q[i-1];
                        if (valid_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                        end
                    end
                end
            end

            assign out_valid = valid_q[STAGES-1];
            assign out_err   = err_q[STAGES-1];
            assign out_data  = data_q[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bank_p.sv
`default_nettype none
// mem_bank_p -- parametrised single-port memory with self-clearing init, byte strobes and probe.
// Rev 1.0
module mem_bank_p
    import mem_bank_pkg::*;
#(
    parameter int          DW         = 16,
    parameter int          AW         = 16,
    parameter int          DEPTH      = 4096,
    parameter int          RD_LAT     = 1,
    parameter int unsigned PROBE_ADDR = 'h05AA
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ,
    input  logic            WR,
    input  logic [AW-1:0]   ADDR,
    input  logic [DW-1:0]   WDBUS,
    input  logic [DW/8-1:0] WSTRB,
    output logic            READY,
    output logic [DW-1:0]   RDBUS,
    output logic            RVALID,
    output logic            ERR,
    output logic [DW-1:0]   RESULT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          in_range;
    logic          wr_acc;
    logic          rd_acc;
    logic [PW-1:0] idx;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] merged;
    logic [DW-1:0] probe_merged;

    logic          rd_valid;
    logic          rd_err;
    logic [DW-1:0] rd_data;
    logic          wr_err;
    logic          pipe_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                ptr <= ptr + PW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (ptr == PW'(DEPTH - 1)) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    assign READY    = (state == S_RUN);
    assign accept   = REQ && READY;
    // One extra bit so DEPTH == 2**AW still compares correctly.
    assign in_range = ({1'b0, ADDR} < (AW + 1)'(DEPTH));
    assign wr_acc   = accept && WR && in_range;
    assign rd_acc   = accept && !WR;
    assign idx      = ADDR[PW-1:0];
    assign rd_word  = mem[idx];

    assign merged       = DW'(byte_merge(MAX_DW'(rd_word), MAX_DW'(WDBUS), MAX_LANES'(WSTRB)));
    assign probe_merged = DW'(byte_merge(MAX_DW'(RESULT), MAX_DW'(WDBUS), MAX_LANES'(WSTRB)));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == S_INIT) begin
                mem[ptr] <= '0;
            end else if (wr_acc) begin
                mem[idx] <= merged;
            end
        end
    end

    // First read register; out-of-range reads return zero with an error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            rd_err   <= rd_acc && !in_range;
            wr_err   <= accept && WR && !in_range;
            if (rd_acc) begin
                rd_data <= in_range ? rd_word : '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT <= '0;
        end else if (wr_acc && (ADDR == AW'(PROBE_ADDR))) begin
            RESULT <= probe_merged;
        end
    end

    mem_rd_pipe #(
        .DW     (DW),
        .STAGES (RD_LAT - 1)
    ) u_rd_pipe (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (rd_valid),
        .in_err    (rd_err),
        .in_data   (rd_data),
        .out_valid (RVALID),
        .out_err   (pipe_err),
        .out_data  (RDBUS)
    );

    assign ERR = pipe_err || wr_err;

endmodule
`default_nettype wire
